// File: rtl/axilite_slave_responder_if.sv
// ---------------------------------------------------------------------------
// axilite_slave_responder_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) shared by a master and a slave.
//   ADDR_W : byte address width
//   DATA_W : data width; strobe width is DATA_W/8
// Modports:
//   master : drives addresses, write data, valids and response readies
//   slave  : drives address/data readies and the B/R responses
// ---------------------------------------------------------------------------
interface axilite_slave_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axilite_slave_responder.sv
// ---------------------------------------------------------------------------
// axilite_slave_responder
// AXI4-Lite slave backed by a DEPTH x DATA_WIDTH register file. Terminates
// write and read traffic and returns OKAY, or SLVERR for addresses beyond the
// register file.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset
//   s_axi : AXI4-Lite bus, slave modport (AW/W/B/AR/R channels)
// ---------------------------------------------------------------------------
module axilite_slave_responder #(
  parameter int AXILITE_ADDR_WIDTH = 64,
  parameter int AXILITE_DATA_WIDTH = 64,
  parameter int DEPTH              = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  axilite_slave_responder_if.slave  s_axi
);

  localparam int STRB_W = AXILITE_DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [AXILITE_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXILITE_DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_W-1:0]             strb_t;
  typedef logic [IDX_W-1:0]              idx_t;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  // Any address bit above the index field means the access misses the file.
  function automatic logic addr_in_range(input addr_t a);
    return ((a >> OFF) >> IDX_W) == '0;
  endfunction

  // Word index; the byte-offset bits below OFF are discarded.
  function automatic idx_t addr_idx(input addr_t a);
    return idx_t'(a >> OFF);
  endfunction

  // ---------------- state ----------------
  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic  aw_held_q, aw_held_d;
  addr_t awaddr_q,  awaddr_d;
  logic  w_held_q,  w_held_d;
  data_t wdata_q,   wdata_d;
  strb_t wstrb_q,   wstrb_d;

  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q,  bresp_d;
  logic       rvalid_q, rvalid_d;
  logic [1:0] rresp_q,  rresp_d;
  data_t      rdata_q,  rdata_d;

  data_t mem_q [DEPTH];

  // ---------------- handshakes ----------------
  logic aw_ready, w_ready, ar_ready;
  logic aw_fire, w_fire, ar_fire;

  assign aw_ready = !rst && (wr_state_q == WR_IDLE) && !aw_held_q;
  assign w_ready  = !rst && (wr_state_q == WR_IDLE) && !w_held_q;
  assign ar_ready = !rst && (rd_state_q == RD_IDLE);

  assign aw_fire = s_axi.awvalid && aw_ready;
  assign w_fire  = s_axi.wvalid  && w_ready;
  assign ar_fire = s_axi.arvalid && ar_ready;

  // The effective write operands come from the holding registers when the
  // channel was accepted earlier, otherwise straight from the bus.
  addr_t wr_addr;
  data_t wr_data;
  strb_t wr_strb;
  logic  wr_commit;
  logic  wr_in_range;
  idx_t  wr_idx;
  data_t wr_bmask;

  assign wr_addr     = aw_held_q ? awaddr_q : s_axi.awaddr;
  assign wr_data     = w_held_q  ? wdata_q  : s_axi.wdata;
  assign wr_strb     = w_held_q  ? wstrb_q  : s_axi.wstrb;
  assign wr_commit   = (wr_state_q == WR_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign wr_in_range = addr_in_range(wr_addr);
  assign wr_idx      = addr_idx(wr_addr);

  // Expand byte strobes into a bit mask.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_bmask
      assign wr_bmask[8*gi +: 8] = {8{wr_strb[gi]}};
    end
  endgenerate

  // ---------------- write FSM next state ----------------
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (wr_commit) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // ---------------- read FSM next state ----------------
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_fire) begin
          // mem_q is sampled before any same-edge write lands: read-before-write.
          if (addr_in_range(s_axi.araddr)) begin
            rdata_d = mem_q[addr_idx(s_axi.araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Register file: cleared on reset, byte-masked write on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_commit && wr_in_range) begin
      mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_bmask) | (wr_data & wr_bmask);
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.arready = ar_ready;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

endmodule
